// File: rtl/sd_dat_sequencer.sv
// sd_dat_sequencer: control-only sequencer for the sd_dat data-line engine.
// Latches a transfer descriptor, issues start/stop pulses to sd_dat, runs an
// SD-clock watchdog, counts blocks from FIFO traffic and reports one status.
// Optional feature macro: SD_DAT_SEQUENCER_WRITE_EN (enables write transfers).
module sd_dat_sequencer #(
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_sd_clk_strobe_rising,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_direction,
    input  logic                 i_width,
    input  logic [6:0]           i_block_size,
    input  logic [10:0]          i_num_blocks,
    input  logic [TIMEOUT_W-1:0] i_timeout,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_status,
    output logic [11:0]          o_blocks_done,
    output logic                 o_dat_width,
    output logic                 o_dat_direction,
    output logic [6:0]           o_dat_block_size,
    output logic [10:0]          o_dat_num_blocks,
    output logic                 o_dat_start,
    output logic                 o_dat_stop,
    input  logic                 i_dat_busy,
    input  logic                 i_dat_crc_error,
    input  logic                 i_rx_fifo_push,
    input  logic                 i_rx_fifo_overrun,
    input  logic                 i_tx_fifo_pop
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARM       = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [2:0] STS_OK          = 3'd0;
    localparam logic [2:0] STS_CRC         = 3'd1;
    localparam logic [2:0] STS_TIMEOUT     = 3'd2;
    localparam logic [2:0] STS_OVERRUN     = 3'd3;
    localparam logic [2:0] STS_ABORT       = 3'd4;
    localparam logic [2:0] STS_LENGTH      = 3'd5;
    localparam logic [2:0] STS_UNSUPPORTED = 3'd6;

    localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [2:0]           state;
    logic [2:0]           result;
    logic [6:0]           word_cnt;
    logic [TIMEOUT_W-1:0] watchdog;
    logic                 overrun_flag;
    logic                 first_run;

    logic                 fifo_event;
    logic                 overrun_in;
    logic                 start_dir;
    logic                 start_ok;
    logic                 block_end;
    logic [11:0]          blocks_next;
    logic                 overrun_next;
    logic                 timeout_hit;
    logic [2:0]           done_status;

`ifdef SD_DAT_SEQUENCER_WRITE_EN
    // Direction-dependent FIFO event source; writes are fully supported
    always_comb begin
        fifo_event = o_dat_direction ? i_tx_fifo_pop : i_rx_fifo_push;
        overrun_in = i_rx_fifo_overrun & ~o_dat_direction;
        start_dir  = i_direction;
        start_ok   = 1'b1;
    end
`else
    logic unused_tx_fifo_pop;

    // Read-only build: writes are rejected at start and tx traffic is ignored
    always_comb begin
        unused_tx_fifo_pop = i_tx_fifo_pop;
        fifo_event         = i_rx_fifo_push;
        overrun_in         = i_rx_fifo_overrun;
        start_dir          = 1'b0;
        start_ok           = ~i_direction;
    end
`endif

    // Next-cycle block count and completion status, so a FIFO event that
    // coincides with busy falling is included in the length check
    always_comb begin
        block_end    = fifo_event && (word_cnt == o_dat_block_size);
        blocks_next  = o_blocks_done + {11'd0, block_end};
        overrun_next = overrun_flag | overrun_in;
        timeout_hit  = (i_timeout != '0) && (watchdog == i_timeout);
        if (i_dat_crc_error)
            done_status = STS_CRC;
        else if (overrun_next)
            done_status = STS_OVERRUN;
        else if (blocks_next != ({1'b0, o_dat_num_blocks} + 12'd1))
            done_status = STS_LENGTH;
        else
            done_status = STS_OK;
    end

    // Busy whenever the sequencer is outside IDLE
    always_comb begin
        o_busy = (state != ST_IDLE);
    end

    // Transfer state machine, counters and registered control outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= ST_IDLE;
            result           <= STS_OK;
            word_cnt         <= '0;
            watchdog         <= '0;
            overrun_flag     <= 1'b0;
            first_run        <= 1'b0;
            o_done           <= 1'b0;
            o_status         <= '0;
            o_blocks_done    <= '0;
            o_dat_width      <= 1'b0;
            o_dat_direction  <= 1'b0;
            o_dat_block_size <= '0;
            o_dat_num_blocks <= '0;
            o_dat_start      <= 1'b0;
            o_dat_stop       <= 1'b0;
        end else begin
            o_dat_start <= 1'b0;
            o_dat_stop  <= 1'b0;
            o_done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_dat_width      <= i_width;
                        o_dat_direction  <= start_dir;
                        o_dat_block_size <= i_block_size;
                        o_dat_num_blocks <= i_num_blocks;
                        o_blocks_done    <= '0;
                        word_cnt         <= '0;
                        watchdog         <= '0;
                        overrun_flag     <= 1'b0;
                        if (start_ok) begin
                            state <= ST_ARM;
                        end else begin
                            result <= STS_UNSUPPORTED;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_ARM: begin
                    if (i_abort) begin
                        o_dat_stop <= 1'b1;
                        result     <= STS_ABORT;
                        state      <= ST_WAIT_IDLE;
                    end else begin
                        o_dat_start <= 1'b1;
                        first_run   <= 1'b1;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    first_run    <= 1'b0;
                    overrun_flag <= overrun_next;
                    if (fifo_event) begin
                        watchdog <= '0;
                        if (block_end) begin
                            word_cnt      <= '0;
                            o_blocks_done <= blocks_next;
                        end else begin
                            word_cnt <= word_cnt + 7'd1;
                        end
                    end else if (i_sd_clk_strobe_rising && (watchdog != '1)) begin
                        watchdog <= watchdog + WD_ONE;
                    end
                    if (!i_dat_busy && !first_run) begin
                        result <= done_status;
                        state  <= ST_DONE;
                    end else if (i_abort) begin
                        o_dat_stop <= 1'b1;
                        result     <= STS_ABORT;
                        state      <= ST_WAIT_IDLE;
                    end else if (timeout_hit) begin
                        o_dat_stop <= 1'b1;
                        result     <= STS_TIMEOUT;
                        state      <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!i_dat_busy)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    o_done   <= 1'b1;
                    o_status <= result;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_sequencer.sv
// Self-checking bench for sd_dat_sequencer (default build, read-only).
module tb_sd_dat_sequencer;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_sd_clk_strobe_rising = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_direction = 1'b0;
    logic          i_width = 1'b0;
    logic [6:0]    i_block_size = '0;
    logic [10:0]   i_num_blocks = '0;
    logic [TW-1:0] i_timeout = '0;
    logic          i_dat_busy = 1'b0;
    logic          i_dat_crc_error = 1'b0;
    logic          i_rx_fifo_push = 1'b0;
    logic          i_rx_fifo_overrun = 1'b0;
    logic          i_tx_fifo_pop = 1'b0;
    logic          o_busy, o_done, o_dat_width, o_dat_direction, o_dat_start, o_dat_stop;
    logic [2:0]    o_status;
    logic [11:0]   o_blocks_done;
    logic [6:0]    o_dat_block_size;
    logic [10:0]   o_dat_num_blocks;

    sd_dat_sequencer #(.TIMEOUT_W(TW)) dut (
        .i_clk                  (clk),
        .i_reset_n              (rst_n),
        .i_sd_clk_strobe_rising (i_sd_clk_strobe_rising),
        .i_start                (i_start),
        .i_abort                (i_abort),
        .i_direction            (i_direction),
        .i_width                (i_width),
        .i_block_size           (i_block_size),
        .i_num_blocks           (i_num_blocks),
        .i_timeout              (i_timeout),
        .o_busy                 (o_busy),
        .o_done                 (o_done),
        .o_status               (o_status),
        .o_blocks_done          (o_blocks_done),
        .o_dat_width            (o_dat_width),
        .o_dat_direction        (o_dat_direction),
        .o_dat_block_size       (o_dat_block_size),
        .o_dat_num_blocks       (o_dat_num_blocks),
        .o_dat_start            (o_dat_start),
        .o_dat_stop             (o_dat_stop),
        .i_dat_busy             (i_dat_busy),
        .i_dat_crc_error        (i_dat_crc_error),
        .i_rx_fifo_push         (i_rx_fifo_push),
        .i_rx_fifo_overrun      (i_rx_fifo_overrun),
        .i_tx_fifo_pop          (i_tx_fifo_pop)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int done_cnt = 0;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (o_dat_start) start_cnt++;
        if (o_dat_stop)  stop_cnt++;
        if (o_done)      done_cnt++;
    end

    typedef struct {
        logic        width;
        logic [6:0]  bs;
        logic [10:0] nb;
        int          words;
        logic        crc;
        logic        ovr;
        logic        abt;
        logic        merge;
        logic [2:0]  exp_status;
        int          exp_blocks;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic dir, input logic width, input logic [6:0] bs,
                              input logic [10:0] nb, input logic [TW-1:0] tmo);
        i_direction  = dir;
        i_width      = width;
        i_block_size = bs;
        i_num_blocks = nb;
        i_timeout    = tmo;
        i_start      = 1'b1;
        tick;
        i_start      = 1'b0;
    endtask

    // Complete read transfer driven by a simple sd_dat behaviour
    task automatic run_xfer(input logic width, input logic [6:0] bs, input logic [10:0] nb,
                            input int words, input logic crc, input logic ovr, input logic abt,
                            input logic merge, input logic [2:0] exp_status, input int exp_blocks);
        int s0, p0, d0, body;
        logic do_merge;
        s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
        do_merge = merge && (words > 0);
        start_xfer(1'b0, width, bs, nb, '0);
        chk("busy_at_start", o_busy, 1);
        chk("latched_size", o_dat_block_size, bs);
        chk("latched_count", o_dat_num_blocks, nb);
        chk("latched_width", o_dat_width, width);
        chk("blocks_cleared", o_blocks_done, 0);
        tick;
        chk("dat_start", o_dat_start, 1);
        i_dat_busy = 1'b1;
        tick;
        body = do_merge ? words - 1 : words;
        for (int w = 0; w < body; w++) begin
            repeat ($urandom_range(2, 0)) begin
                i_sd_clk_strobe_rising = 1'($urandom_range(1, 0));
                tick;
            end
            i_rx_fifo_push = 1'b1;
            i_sd_clk_strobe_rising = 1'($urandom_range(1, 0));
            tick;
            i_rx_fifo_push = 1'b0;
        end
        if (ovr) begin
            i_rx_fifo_overrun = 1'b1;
            tick;
            i_rx_fifo_overrun = 1'b0;
        end
        i_sd_clk_strobe_rising = 1'b0;
        i_dat_busy      = 1'b0;
        i_dat_crc_error = crc;
        i_abort         = abt;
        i_rx_fifo_push  = do_merge;
        tick;
        i_dat_crc_error = 1'b0;
        i_abort         = 1'b0;
        i_rx_fifo_push  = 1'b0;
        chk("done_not_early", o_done, 0);
        tick;
        chk("done_pulse", o_done, 1);
        chk("status", o_status, exp_status);
        chk("blocks_done", o_blocks_done, exp_blocks);
        tick;
        chk("done_single", o_done, 0);
        chk("idle_after", o_busy, 0);
        chk("start_pulses", start_cnt - s0, 1);
        chk("stop_pulses", stop_cnt - p0, 0);
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int s0, p0, d0, n, per, words, exp_blocks;
        logic seen, crc, ovr, abt, merge;
        logic [6:0] bs;
        logic [10:0] nb;
        logic [2:0] exp_status;

        //            width bs      nb      words crc   ovr   abt   merge status blocks
        tbl[0] = '{1'b1, 7'd127, 11'd1, 256, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2};
        tbl[1] = '{1'b1, 7'd127, 11'd1, 256, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 2};
        tbl[2] = '{1'b0, 7'd3,   11'd3, 12,  1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3};
        tbl[3] = '{1'b0, 7'd0,   11'd4, 5,   1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5};
        tbl[4] = '{1'b1, 7'd7,   11'd0, 8,   1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1};
        tbl[5] = '{1'b0, 7'd7,   11'd0, 8,   1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1};
        tbl[6] = '{1'b1, 7'd1,   11'd2, 6,   1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3};
        tbl[7] = '{1'b0, 7'd5,   11'd1, 11,  1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_status", o_status, 0);
        chk("rst_blocks", o_blocks_done, 0);
        chk("rst_dat_start", o_dat_start, 0);
        chk("rst_dat_stop", o_dat_stop, 0);
        chk("rst_dat_size", o_dat_block_size, 0);
        rst_n = 1'b1;
        tick;

        // Table-driven transfers
        for (int i = 0; i < 8; i++)
            run_xfer(tbl[i].width, tbl[i].bs, tbl[i].nb, tbl[i].words, tbl[i].crc, tbl[i].ovr,
                     tbl[i].abt, tbl[i].merge, tbl[i].exp_status, tbl[i].exp_blocks);

        // Write request in read-only build; a start in the DONE cycle is ignored
        s0 = start_cnt; d0 = done_cnt;
        start_xfer(1'b1, 1'b1, 7'd3, 11'd0, '0);
        chk("unsup_busy", o_busy, 1);
        chk("unsup_dir", o_dat_direction, 0);
        chk("unsup_done_early", o_done, 0);
        i_direction = 1'b0;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        chk("unsup_done", o_done, 1);
        chk("unsup_status", o_status, 6);
        chk("start_in_done_ignored", o_busy, 0);
        tick;
        chk("unsup_idle", o_busy, 0);
        chk("unsup_no_start", start_cnt - s0, 0);
        chk("unsup_done_cnt", done_cnt - d0, 1);

        // Abort while arming
        s0 = start_cnt; p0 = stop_cnt;
        start_xfer(1'b0, 1'b0, 7'd3, 11'd0, '0);
        i_abort = 1'b1;
        tick;
        i_abort = 1'b0;
        chk("arm_abort_no_start", o_dat_start, 0);
        chk("arm_abort_stop", o_dat_stop, 1);
        tick;
        chk("arm_abort_stop_single", o_dat_stop, 0);
        chk("arm_abort_done_early", o_done, 0);
        tick;
        chk("arm_abort_done", o_done, 1);
        chk("arm_abort_status", o_status, 4);
        chk("arm_abort_start_cnt", start_cnt - s0, 0);
        chk("arm_abort_stop_cnt", stop_cnt - p0, 1);
        tick;

        // Abort 3 cycles into RUN, second start during WAIT_IDLE ignored
        s0 = start_cnt; p0 = stop_cnt;
        start_xfer(1'b0, 1'b1, 7'd15, 11'd2, '0);
        tick;
        i_dat_busy = 1'b1;
        tick;
        tick;
        i_abort = 1'b1;
        tick;
        i_abort = 1'b0;
        chk("run_abort_stop", o_dat_stop, 1);
        i_block_size = 7'd99;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        chk("run_abort_stop_single", o_dat_stop, 0);
        chk("wait_busy", o_busy, 1);
        chk("wait_descr_held", o_dat_block_size, 15);
        repeat (2) tick;
        chk("wait_no_done", o_done, 0);
        i_dat_busy = 1'b0;
        tick;
        tick;
        chk("run_abort_done", o_done, 1);
        chk("run_abort_status", o_status, 4);
        tick;
        chk("run_abort_idle", o_busy, 0);
        chk("run_abort_start_cnt", start_cnt - s0, 1);
        chk("run_abort_stop_cnt", stop_cnt - p0, 1);

        // Watchdog timeout after 100 SD strobes with no FIFO traffic
        p0 = stop_cnt;
        start_xfer(1'b0, 1'b0, 7'd7, 11'd0, 24'd100);
        tick;
        i_dat_busy = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            i_sd_clk_strobe_rising = (k % 2 == 0);
            tick;
            if (i_sd_clk_strobe_rising) n++;
            if (o_dat_stop) seen = 1'b1;
        end
        i_sd_clk_strobe_rising = 1'b0;
        chk("timeout_stop_seen", seen, 1);
        chk("timeout_strobes", n, 100);
        tick;
        chk("timeout_stop_single", o_dat_stop, 0);
        repeat (3) tick;
        chk("timeout_wait_busy", o_busy, 1);
        i_dat_busy = 1'b0;
        tick;
        tick;
        chk("timeout_done", o_done, 1);
        chk("timeout_status", o_status, 2);
        chk("timeout_stop_cnt", stop_cnt - p0, 1);
        i_timeout = '0;
        tick;

        // Asynchronous reset in the middle of a transfer
        start_xfer(1'b0, 1'b1, 7'd0, 11'd9, '0);
        tick;
        i_dat_busy = 1'b1;
        tick;
        repeat (3) begin
            i_rx_fifo_push = 1'b1;
            tick;
        end
        i_rx_fifo_push = 1'b0;
        chk("pre_reset_blocks", o_blocks_done, 3);
        p0 = stop_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", o_busy, 0);
        chk("async_rst_blocks", o_blocks_done, 0);
        chk("async_rst_status", o_status, 0);
        chk("async_rst_width", o_dat_width, 0);
        chk("async_rst_count", o_dat_num_blocks, 0);
        i_dat_busy = 1'b0;
        #2 rst_n = 1'b1;
        tick;
        chk("post_rst_idle", o_busy, 0);
        chk("post_rst_no_stop", stop_cnt - p0, 0);

        // Randomized reads against an arithmetic reference
        for (int r = 0; r < 24; r++) begin
            bs    = 7'($urandom_range(15, 0));
            nb    = 11'($urandom_range(3, 0));
            per   = int'(bs) + 1;
            words = ($urandom_range(1, 0) == 1) ? per * (int'(nb) + 1)
                                               : int'($urandom_range(per * (int'(nb) + 2) + per - 1, 0));
            crc   = ($urandom_range(5, 0) == 0);
            ovr   = ($urandom_range(5, 0) == 0);
            abt   = ($urandom_range(3, 0) == 0);
            merge = 1'($urandom_range(1, 0));
            exp_blocks = words / per;
            if (crc)                           exp_status = 3'd1;
            else if (ovr)                      exp_status = 3'd3;
            else if (exp_blocks != int'(nb) + 1) exp_status = 3'd5;
            else                               exp_status = 3'd0;
            run_xfer(1'($urandom_range(1, 0)), bs, nb, words, crc, ovr, abt, merge,
                     exp_status, exp_blocks);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
